// File: rtl/uart_rx_ctrl.sv
//-----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive side of the BASYS3 USB-UART link. This is the counterpart of
// uart_tx_ctrl. The block accepts 8N1 frames at BAUD on the RsRx line.
//   - The line is oversampled OVERSAMPLE times per bit.
//   - Bits are sampled at mid-bit, with the sampling phase aligned to the
//     falling edge of the start bit.
//   - Bytes are assembled LSB first.
//   - Each good byte lands in a one-entry holding register that a consumer
//     drains with a valid/ready handshake.
//
// Optional feature (macro UART_RX_PARITY_EN):
//   - The frame becomes 8E1.
//   - A parity bit is sampled after data bit 7.
//   - An extra output, parity_err, pulses when the parity check fails.
//   - A byte that fails parity is dropped.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line baud rate
//   OVERSAMPLE  sample ticks per bit period (even, >= 8)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   RsRx        raw serial line, idle high, asynchronous to clk
//   rx_ready    consumer accepts rx_data while rx_valid is high
//   rx_data     received byte, stable while rx_valid is high
//   rx_valid    holding register full
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun     one-cycle pulse, byte completed while holding register full
//   parity_err  (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
//   busy        high from start-bit detection until the FSM is back in IDLE
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_ctrl #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  // The divider value is truncated. A value of 0 would only come from a
  // nonsensical parameter set, so it is clamped to 1.
  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(DIV + 1);
  localparam int SW      = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_prev_q, rx_prev_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            commit_q, commit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
`endif

  logic            rx_fall;
  logic            tick;

  // Next-state logic covers three parts of the receiver.
  //   - Synchronizer and edge detect: the falling edge is taken from the
  //     synchronized line and its one-cycle delayed copy.
  //   - Tick divider: it is parked at 0 whenever the FSM is not timing a bit.
  //     Because of that, the first tick after the start edge always arrives
  //     DIV clocks later, which keeps the mid-bit sampling phase tied to that
  //     edge.
  //   - Holding register: a good byte is committed one cycle after the stop
  //     sample. At that point it either loads or is reported as an overrun.
  always_comb begin
    sync1_d      = RsRx;
    rx_s_d       = sync1_q;
    rx_prev_d    = rx_s_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    os_cnt_d     = os_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    commit_d     = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    rx_fall = rx_prev_q & ~rx_s_q;
    tick    = (tick_cnt_q == DIV_LAST);

    if (state_q == IDLE || state_q == WAIT_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (rx_fall) begin
          state_d = START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end

      START: begin
        if (tick) begin
          if (os_cnt_q == HALF_LAST) begin
            os_cnt_d = '0;
            // A line that is already high again at mid start bit was only a
            // glitch, so it is dropped without any pulse.
            if (!rx_s_q) begin
              state_d   = DATA;
              bit_idx_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d           = '0;
            shift_d[bit_idx_q] = rx_s_q;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            os_cnt_d = os_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d     = '0;
            par_bad_d    = (^shift_q) ^ rx_s_q;
            parity_err_d = (^shift_q) ^ rx_s_q;
            state_d      = STOP;
          end else begin
            os_cnt_d = os_cnt_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              commit_d = ~par_bad_q;
`else
              commit_d = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + SW'(1);
          end
        end
      end

      // A break (line held low) must not look like a stream of new start
      // bits, so the FSM waits for the line to go idle first.
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (commit_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // All state in the block is registered here. The synchronizer resets to the
  // idle line level so that reset release is never mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      tick_cnt_q   <= '0;
      os_cnt_q     <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      commit_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      commit_q     <= commit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
//-----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl.
//   - The receiver runs with a small clock divider (DIV = 4) so that whole
//     frames are short.
//   - Frames are built bit by bit from their byte value.
//   - The expected deliveries, error pulses and overruns come from a
//     frame-level model: a queue of good bytes, plus the rule that a full
//     holding register turns the next good byte into an overrun.
//
// Optional feature: macro UART_RX_PARITY_EN.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  localparam int CLK_FREQ = 640000;
  localparam int BAUD     = 10000;
  localparam int OVS      = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OVS);
  localparam int BIT_CLKS = DIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_HALF_BITS = 2 * 10 + 1;
`else
  localparam int FRAME_HALF_BITS = 2 * 9 + 1;
`endif
  // Latency is counted in negedges, starting from the line's falling edge.
  // The total is FRAME_HALF_BITS half bits, plus synchronizer and commit
  // cycles.
  localparam int LAT_EXP = FRAME_HALF_BITS * BIT_CLKS / 2 + 5;

  logic       clk;
  logic       rst_n;
  logic       RsRx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         nChecks;
  int         nPassed;
  logic [7:0] gotQ[$];
  int         feCnt;
  int         ovCnt;
  int         peCnt;
  bit         busySeen;

  uart_rx_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RsRx(RsRx),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  // 100 MHz-style clock; the divider is what sets the bit time.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor on the falling edge.
  //   - Records every accepted byte.
  //   - Counts the cycles in which each error pulse is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) gotQ.push_back(rx_data);
      if (frame_err) feCnt++;
      if (overrun) ovCnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) peCnt++;
`endif
      if (busy) busySeen = 1'b1;
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) begin
      nPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearCounts();
    gotQ.delete();
    feCnt    = 0;
    ovCnt    = 0;
    peCnt    = 0;
    busySeen = 1'b0;
  endtask

  task automatic waitClks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleBits(input int n);
    RsRx = 1'b1;
    waitClks(n * BIT_CLKS);
  endtask

  // Drives one frame on RsRx.
  //   - parFlip inverts the parity bit (parity builds only).
  //   - maxClks > 0 aborts the frame after that many clocks.
  //   - On return from a bad-stop frame the line is still low.
  task automatic applyStimulus(input logic [7:0] data, input bit stopOk, input bit parFlip,
                               input int maxClks);
    logic [11:0] fb;
    int          n;
    int          clks;
    fb    = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i + 1] = data[i];
    n = 9;
`ifdef UART_RX_PARITY_EN
    fb[9] = (^data) ^ parFlip;
    n = 10;
`endif
    fb[n] = stopOk;
    n++;
    clks = 0;
    for (int b = 0; b < n; b++) begin
      RsRx = fb[b];
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (maxClks > 0 && clks == maxClks) return;
        @(posedge clk);
        #1;
        clks++;
      end
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [7:0] d;
    logic [7:0] firstGood;
    bit         ok;
    bit         flip;
    bit         haveFirst;
    int         nBad;
    int         nGood;
    int         nParBad;
    logic [7:0] expQ[$];

    nChecks  = 0;
    nPassed  = 0;
    clearCounts();
    rst_n    = 1'b0;
    RsRx     = 1'b1;
    rx_ready = 1'b0;
    waitClks(5);
    @(negedge clk);
    checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleBits(2);

    // Single byte with rx_ready low, including the latency window.
    $display("[TB] frame 0x41, latency");
    clearCounts();
    lat = 0;
    fork
      applyStimulus(8'h41, 1'b1, 1'b0, 0);
      begin
        for (int i = 0; i < 3 * FRAME_HALF_BITS * BIT_CLKS; i++) begin
          @(negedge clk);
          lat++;
          if (rx_valid) break;
        end
      end
    join
    $display("[TB] latency %0d clocks, nominal %0d", lat, LAT_EXP);
    checkOutput("latency_in_window", 32'((lat >= LAT_EXP - 20) && (lat <= LAT_EXP + 20)), 32'h1);
    idleBits(1);
    @(negedge clk);
    checkOutput("t1_rx_valid", 32'(rx_valid), 32'h1);
    checkOutput("t1_rx_data", 32'(rx_data), 32'h41);
    checkOutput("t1_frame_err", 32'(feCnt), 32'h0);
    checkOutput("t1_overrun", 32'(ovCnt), 32'h0);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    checkOutput("t1_valid_cleared", 32'(rx_valid), 32'h0);
    checkOutput("t1_accepted_cnt", 32'(gotQ.size()), 32'h1);

    // Short low glitch, shorter than half a bit.
    $display("[TB] start glitch");
    clearCounts();
    RsRx = 1'b0;
    waitClks(BIT_CLKS / 2 - 12);
    idleBits(2);
    @(negedge clk);
    checkOutput("t2_busy_seen", 32'(busySeen), 32'h1);
    checkOutput("t2_busy_low", 32'(busy), 32'h0);
    checkOutput("t2_no_valid", 32'(rx_valid), 32'h0);
    checkOutput("t2_no_frame_err", 32'(feCnt), 32'h0);

    // Bad stop bit followed by a break, then a clean frame.
    $display("[TB] frame error then 0xA5");
    clearCounts();
    applyStimulus(8'h55, 1'b0, 1'b0, 0);
    waitClks(2 * BIT_CLKS);
    idleBits(1);
    @(negedge clk);
    checkOutput("t3_frame_err_pulses", 32'(feCnt), 32'h1);
    checkOutput("t3_no_valid", 32'(rx_valid), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(8'hA5, 1'b1, 1'b0, 0);
    idleBits(1);
    @(negedge clk);
    checkOutput("t3_rx_valid", 32'(rx_valid), 32'h1);
    checkOutput("t3_rx_data", 32'(rx_data), 32'hA5);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back frames with no consumer: the second byte overruns.
    $display("[TB] back-to-back, rx_ready low");
    clearCounts();
    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 0);
    idleBits(1);
    @(negedge clk);
    checkOutput("t4_rx_valid", 32'(rx_valid), 32'h1);
    checkOutput("t4_rx_data", 32'(rx_data), 32'h00);
    checkOutput("t4_overrun_pulses", 32'(ovCnt), 32'h1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back frames with the consumer always ready.
    $display("[TB] back-to-back, rx_ready high");
    clearCounts();
    rx_ready = 1'b1;
    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 0);
    idleBits(1);
    @(negedge clk);
    checkOutput("t5_accepted_cnt", 32'(gotQ.size()), 32'h2);
    if (gotQ.size() == 2) begin
      checkOutput("t5_byte0", 32'(gotQ[0]), 32'h00);
      checkOutput("t5_byte1", 32'(gotQ[1]), 32'hFF);
    end
    checkOutput("t5_no_overrun", 32'(ovCnt), 32'h0);
    checkOutput("t5_valid_low", 32'(rx_valid), 32'h0);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;

    // Reset in the middle of data bit 4 while a byte is being held.
    $display("[TB] reset mid-frame");
    clearCounts();
    applyStimulus(8'hC3, 1'b1, 1'b0, 0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 5 * BIT_CLKS + BIT_CLKS / 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("t6_rst_rx_data", 32'(rx_data), 32'h00);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("t6_rst_overrun", 32'(overrun), 32'h0);
    RsRx = 1'b1;
    waitClks(4);
    rst_n = 1'b1;
    clearCounts();
    idleBits(2);
    applyStimulus(8'h7E, 1'b1, 1'b0, 0);
    idleBits(1);
    @(negedge clk);
    checkOutput("t6_rx_valid", 32'(rx_valid), 32'h1);
    checkOutput("t6_rx_data", 32'(rx_data), 32'h7E);
    checkOutput("t6_no_errors", 32'(feCnt + ovCnt), 32'h0);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    checkOutput("t6_accepted_cnt", 32'(gotQ.size()), 32'h1);
    @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is wrong.
    $display("[TB] parity error");
    clearCounts();
    applyStimulus(8'h07, 1'b1, 1'b1, 0);
    idleBits(1);
    @(negedge clk);
    checkOutput("tp_parity_err_pulses", 32'(peCnt), 32'h1);
    checkOutput("tp_no_valid", 32'(rx_valid), 32'h0);
    checkOutput("tp_no_frame_err", 32'(feCnt), 32'h0);
    @(posedge clk);
    #1;
`endif

    // Random frames, consumer always ready: every good byte is delivered in
    // order.
    $display("[TB] random frames, rx_ready high");
    clearCounts();
    expQ.delete();
    nBad    = 0;
    nParBad = 0;
    rx_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      flip = 1'b0;
`ifdef UART_RX_PARITY_EN
      if (ok) flip = ($urandom_range(0, 4) == 0);
`endif
      applyStimulus(d, ok, flip, 0);
      if (!ok) begin
        nBad++;
        waitClks(2 * BIT_CLKS);
      end else if (flip) begin
        nParBad++;
      end else begin
        expQ.push_back(d);
      end
      idleBits($urandom_range(1, 2));
    end
    @(negedge clk);
    checkOutput("ra_accepted_cnt", 32'(gotQ.size()), 32'(expQ.size()));
    if (gotQ.size() == expQ.size()) begin
      for (int i = 0; i < expQ.size(); i++) checkOutput("ra_byte", 32'(gotQ[i]), 32'(expQ[i]));
    end
    checkOutput("ra_frame_err", 32'(feCnt), 32'(nBad));
    checkOutput("ra_overrun", 32'(ovCnt), 32'h0);
`ifdef UART_RX_PARITY_EN
    checkOutput("ra_parity_err", 32'(peCnt), 32'(nParBad));
`endif
    @(posedge clk);
    #1;
    rx_ready = 1'b0;

    // Random frames, no consumer.
    //   - The first good byte is held.
    //   - Every later good byte overruns.
    $display("[TB] random frames, rx_ready low");
    clearCounts();
    nBad      = 0;
    nGood     = 0;
    haveFirst = 1'b0;
    firstGood = 8'h00;
    for (int f = 0; f < 8; f++) begin
      d  = 8'($urandom);
      ok = (f == 0) || ($urandom_range(0, 3) != 0);
      applyStimulus(d, ok, 1'b0, 0);
      if (!ok) begin
        nBad++;
        waitClks(2 * BIT_CLKS);
      end else begin
        nGood++;
        if (!haveFirst) begin
          firstGood = d;
          haveFirst = 1'b1;
        end
      end
      idleBits($urandom_range(1, 2));
    end
    @(negedge clk);
    checkOutput("rb_rx_valid", 32'(rx_valid), 32'h1);
    checkOutput("rb_rx_data", 32'(rx_data), 32'(firstGood));
    checkOutput("rb_overrun", 32'(ovCnt), 32'(nGood - 1));
    checkOutput("rb_frame_err", 32'(feCnt), 32'(nBad));
    checkOutput("rb_none_accepted", 32'(gotQ.size()), 32'h0);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    checkOutput("rb_drained_cnt", 32'(gotQ.size()), 32'h1);
    checkOutput("rb_valid_cleared", 32'(rx_valid), 32'h0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
